// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral exposing a small register file; frames are
// R/W bit, address, data, MSB first, all sampled in the clk domain.
module spi_regfile_peripheral #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       nCS,
    input  logic                       SCLK,
    input  logic                       COPI,
    output logic                       CIPO,
    output logic                       CIPO_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [7:0]                 frame_err_cnt
);
    // state  | meaning
    // IDLE   | waiting for chip select
    // CMD    | shifting R/W bit and address
    // DATA   | shifting data, driving read data on CIPO
    // COMMIT | one cycle to apply a complete write frame
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CMD    = 2'd1;
    localparam logic [1:0] S_DATA   = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_CMD  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

    logic [2:0]                 ncs_sync_q, ncs_sync_d;
    logic [2:0]                 sclk_sync_q, sclk_sync_d;
    logic [2:0]                 copi_sync_q, copi_sync_d;
    logic                       primed_q, primed_d;
    logic                       armed_q, armed_d;
    logic [1:0]                 state_q, state_d;
    logic [CNT_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]         sh_q, sh_d;
    logic [DATA_W-1:0]          tx_q, tx_d;
    logic                       cipo_q, cipo_d;
    logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
    logic                       wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
    logic [7:0]                 err_q, err_d;

    logic              sclk_rise, sclk_fall, ncs_fall, ncs_rise, err_inc;
    logic [ADDR_W-1:0] rd_addr, cm_addr;
    logic [DATA_W-1:0] rd_data, cm_data;
    logic              cm_rw;

    always_comb begin
        ncs_sync_d  = {ncs_sync_q[1:0], nCS};
        sclk_sync_d = {sclk_sync_q[1:0], SCLK};
        copi_sync_d = {copi_sync_q[1:0], COPI};
        sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
        sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
        ncs_rise    = ncs_sync_q[1] & ~ncs_sync_q[2];
        // A frame already in progress at reset release must not look like a new one.
        ncs_fall    = armed_q & ~ncs_sync_q[1] & ncs_sync_q[2];
        primed_d    = 1'b1;
        armed_d     = armed_q | (primed_q & ncs_sync_q[0]);
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        tx_d        = tx_q;
        cipo_d      = cipo_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        err_inc     = 1'b0;
        rd_data     = '0;
        cm_rw       = sh_q[FRAME_W-1];
        cm_addr     = sh_q[FRAME_W-2 -: ADDR_W];
        cm_data     = sh_q[DATA_W-1:0];

        if ((state_q == S_CMD || state_q == S_DATA) && sclk_rise) begin
            sh_d      = {sh_q[FRAME_W-2:0], copi_sync_q[2]};
            bit_cnt_d = (bit_cnt_q == CNT_SAT) ? bit_cnt_q : bit_cnt_q + 1'b1;
        end
        rd_addr = sh_d[ADDR_W-1:0];
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_addr == ADDR_W'(k)) rd_data = regs_q[k*DATA_W +: DATA_W];
        end

        if (state_q == S_DATA && sclk_fall) begin
            cipo_d = tx_q[DATA_W-1];
            tx_d   = tx_q << 1;
        end

        case (state_q)
            S_IDLE: cipo_d = 1'b0;
            S_CMD: begin
                cipo_d = 1'b0;
                if (ncs_rise) begin
                    err_inc = (bit_cnt_q != '0);
                    state_d = S_IDLE;
                end else if (sclk_rise && bit_cnt_q == CNT_CMD) begin
                    state_d = S_DATA;
                    tx_d    = sh_d[ADDR_W] ? '0 : rd_data;
                end
            end
            S_DATA: begin
                if (ncs_rise) begin
                    err_inc = (bit_cnt_q != CNT_FULL);
                    state_d = S_COMMIT;
                end
            end
            default: begin
                cipo_d  = 1'b0;
                state_d = S_IDLE;
                if (bit_cnt_q == CNT_FULL && cm_rw) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (cm_addr == ADDR_W'(k)) begin
                            regs_d[k*DATA_W +: DATA_W] = cm_data;
                            wr_strobe_d                = 1'b1;
                            wr_addr_d                  = cm_addr;
                        end
                    end
                end
            end
        endcase

        // Commit above uses the _q values, so a fall during COMMIT loses nothing.
        if (ncs_fall) begin
            state_d   = S_CMD;
            bit_cnt_d = '0;
            sh_d      = '0;
        end
        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ncs_sync_q  <= 3'b111;
            sclk_sync_q <= 3'b000;
            copi_sync_q <= 3'b000;
            primed_q    <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            tx_q        <= '0;
            cipo_q      <= 1'b0;
            regs_q      <= RESET_VAL;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            err_q       <= '0;
        end else begin
            ncs_sync_q  <= ncs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            primed_q    <= primed_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            tx_q        <= tx_d;
            cipo_q      <= cipo_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            err_q       <= err_d;
        end
    end

    assign CIPO          = cipo_q;
    assign CIPO_oe       = ~ncs_sync_q[2];
    assign regs_out      = regs_q;
    assign wr_strobe     = wr_strobe_q;
    assign wr_addr       = wr_addr_q;
    assign frame_err_cnt = err_q;
endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench for spi_regfile_peripheral: default 8x8 instance plus a
// 4x16 instance sharing SCLK/COPI with its own chip select.
module tb_spi_regfile_peripheral;
    localparam logic [63:0] RV = 64'h0807_0605_0403_0201;
    localparam int HP = 6;

    logic        clk = 1'b0;
    logic        rst, ncs, ncs2, sclk, copi;
    logic        cipo, cipo_oe, stb, cipo2, cipo_oe2, stb2;
    logic [63:0] regs, regs2;
    logic [6:0]  waddr, waddr2;
    logic [7:0]  errc, errc2;

    int tests = 0;
    int fails = 0;
    int stb_cnt = 0;
    int stb2_cnt = 0;

    always #5 clk = ~clk;

    spi_regfile_peripheral #(.RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .nCS(ncs), .SCLK(sclk), .COPI(copi),
        .CIPO(cipo), .CIPO_oe(cipo_oe), .regs_out(regs), .wr_strobe(stb),
        .wr_addr(waddr), .frame_err_cnt(errc));

    spi_regfile_peripheral #(.NUM_REGS(4), .DATA_W(16)) dut2 (
        .clk(clk), .rst(rst), .nCS(ncs2), .SCLK(sclk), .COPI(copi),
        .CIPO(cipo2), .CIPO_oe(cipo_oe2), .regs_out(regs2), .wr_strobe(stb2),
        .wr_addr(waddr2), .frame_err_cnt(errc2));

    always @(negedge clk) begin
        if (stb)  stb_cnt++;
        if (stb2) stb2_cnt++;
    end

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        logic [15:0] exp_rx;
        int          exp_stb;
        int          exp_err;
        bit          upd;
        int          idx;
        logic [7:0]  val;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cs(input bit sel, input logic v);
        if (sel) ncs2 = v;
        else     ncs  = v;
    endtask

    task automatic shift_bits(input logic [31:0] frame, input int fw, input int from,
                              input int to, input bit sel, inout logic [31:0] rx);
        for (int i = from; i < to; i++) begin
            copi = (i < fw) ? frame[fw-1-i] : 1'b0;
            clocks(HP);
            sclk = 1'b1;
            if (i < fw) rx[fw-1-i] = sel ? cipo2 : cipo;
            clocks(HP);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_open(input bit sel);
        set_cs(sel, 1'b0);
        clocks(HP);
    endtask

    task automatic frame_close(input bit sel, input int gap);
        clocks(HP);
        set_cs(sel, 1'b1);
        clocks(gap);
    endtask

    task automatic xfer(input logic [31:0] frame, input int fw, input int nbits,
                        input bit sel, output logic [31:0] rx);
        rx = '0;
        frame_open(sel);
        shift_bits(frame, fw, 0, nbits, sel, rx);
        frame_close(sel, 10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] exp_regs;
        logic [31:0] rx;
        int          s0, e0;

        vecs[0]  = '{16'h8455, 16, 16'h0000, 1, 0, 1, 4, 8'h55};
        vecs[1]  = '{16'h82A3, 16, 16'h0000, 1, 0, 1, 2, 8'hA3};
        vecs[2]  = '{16'h0200, 16, 16'h00A3, 0, 0, 0, 0, 8'h00};
        vecs[3]  = '{16'h7F00, 16, 16'h0000, 0, 0, 0, 0, 8'h00};
        vecs[4]  = '{16'hFF12, 16, 16'h0000, 0, 0, 0, 0, 8'h00};
        vecs[5]  = '{16'h0400, 16, 16'h0055, 0, 0, 0, 0, 8'h00};
        vecs[6]  = '{16'h0300, 16, 16'h0004, 0, 0, 0, 0, 8'h00};
        vecs[7]  = '{16'h8077, 10, 16'h0000, 0, 1, 0, 0, 8'h00};
        vecs[8]  = '{16'h8077,  0, 16'h0000, 0, 0, 0, 0, 8'h00};
        vecs[9]  = '{16'h8077, 17, 16'h0000, 0, 1, 0, 0, 8'h00};
        vecs[10] = '{16'h8701, 16, 16'h0000, 1, 0, 1, 7, 8'h01};
        vecs[11] = '{16'h0700, 16, 16'h0001, 0, 0, 0, 0, 8'h00};

        rst = 1'b1; ncs = 1'b1; ncs2 = 1'b1; sclk = 1'b0; copi = 1'b0;
        clocks(5);
        check("reset regs_out", regs, RV);
        check("reset wr_strobe", {63'd0, stb}, 64'd0);
        check("reset wr_addr", {57'd0, waddr}, 64'd0);
        check("reset err_cnt", {56'd0, errc}, 64'd0);
        check("reset CIPO", {63'd0, cipo}, 64'd0);
        check("reset CIPO_oe", {63'd0, cipo_oe}, 64'd0);
        check("reset dut2 regs_out", regs2, 64'd0);
        rst = 1'b0;
        clocks(5);

        exp_regs = RV;
        for (int v = 0; v < 12; v++) begin
            s0 = stb_cnt;
            e0 = errc;
            xfer({16'h0, vecs[v].frame}, 16, vecs[v].nbits, 1'b0, rx);
            if (vecs[v].upd) exp_regs[vecs[v].idx*8 +: 8] = vecs[v].val;
            if (vecs[v].nbits == 16)
                check($sformatf("vec%0d rx", v), {48'd0, rx[15:0]}, {48'd0, vecs[v].exp_rx});
            check($sformatf("vec%0d strobes", v), 64'(stb_cnt - s0), 64'(vecs[v].exp_stb));
            check($sformatf("vec%0d err delta", v), 64'(int'(errc) - e0), 64'(vecs[v].exp_err));
            check($sformatf("vec%0d regs_out", v), regs, exp_regs);
            if (vecs[v].upd)
                check($sformatf("vec%0d wr_addr", v), {57'd0, waddr}, 64'(vecs[v].idx));
        end

        for (int n = 0; n < 300; n++) xfer(32'h8000, 16, 1, 1'b0, rx);
        check("err_cnt saturates", {56'd0, errc}, 64'd255);
        check("aborts keep regs", regs, exp_regs);

        s0 = stb_cnt;
        rx = '0;
        frame_open(1'b0);
        shift_bits(32'h80AA, 16, 0, 12, 1'b0, rx);
        rst = 1'b1;
        clocks(3);
        rst = 1'b0;
        shift_bits(32'h80AA, 16, 12, 16, 1'b0, rx);
        frame_close(1'b0, 10);
        exp_regs = RV;
        check("midreset regs_out", regs, exp_regs);
        check("midreset strobes", 64'(stb_cnt - s0), 64'd0);
        check("midreset err_cnt", {56'd0, errc}, 64'd0);
        xfer(32'h80AA, 16, 16, 1'b0, rx);
        exp_regs[7:0] = 8'hAA;
        check("post-reset write", regs, exp_regs);
        check("post-reset strobes", 64'(stb_cnt - s0), 64'd1);

        s0 = stb_cnt;
        frame_open(1'b0);
        shift_bits(32'h8111, 16, 0, 16, 1'b0, rx);
        frame_close(1'b0, 2);
        frame_open(1'b0);
        shift_bits(32'h8622, 16, 0, 16, 1'b0, rx);
        frame_close(1'b0, 10);
        exp_regs[15:8]  = 8'h11;
        exp_regs[55:48] = 8'h22;
        check("b2b regs_out", regs, exp_regs);
        check("b2b strobes", 64'(stb_cnt - s0), 64'd2);
        check("b2b wr_addr", {57'd0, waddr}, 64'd6);
        check("b2b err_cnt", {56'd0, errc}, 64'd0);

        s0 = stb2_cnt;
        frame_open(1'b1);
        shift_bits(32'h81BEEF, 24, 0, 24, 1'b1, rx);
        frame_close(1'b1, 2);
        frame_open(1'b1);
        shift_bits(32'h831234, 24, 0, 24, 1'b1, rx);
        frame_close(1'b1, 10);
        check("w16 b2b regs_out", regs2, 64'h1234_0000_BEEF_0000);
        check("w16 b2b strobes", 64'(stb2_cnt - s0), 64'd2);
        check("w16 wr_addr", {57'd0, waddr2}, 64'd3);
        xfer(32'h010000, 24, 24, 1'b1, rx);
        check("w16 read reg1", {40'd0, rx[23:0]}, 64'h00_BEEF);
        check("dut1 untouched by dut2", regs, exp_regs);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_regfile_peripheral.md
SPI_REGFILE_PERIPHERAL -- requirements
Module: spi_regfile_peripheral

Interface
REQ-001 Parameter NUM_REGS, default 8: number of implemented registers, 1..2**ADDR_W.
REQ-002 Parameter ADDR_W, default 7: address field width in bits.
REQ-003 Parameter DATA_W, default 8: register and data field width in bits.
REQ-004 Parameter RESET_VAL, default all zeros, width NUM_REGS*DATA_W: per-register reset contents; register k occupies bits [k*DATA_W +: DATA_W].
REQ-005 Derived constant FRAME_W = 1 + ADDR_W + DATA_W (default 16).
REQ-006 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-007 clk  input  1  system clock; all state changes on its rising edge.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 nCS  input  1  SPI chip select, active low, asynchronous to clk.
REQ-010 SCLK  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-011 COPI  input  1  controller-out data, MSB first.
REQ-012 CIPO  output  1  peripheral-out read data, MSB first.
REQ-013 CIPO_oe  output  1  high while the synchronised nCS is low.
REQ-014 regs_out  output  NUM_REGS*DATA_W  flat register contents, packed as in REQ-004.
REQ-015 wr_strobe  output  1  one-cycle pulse on each committed write.
REQ-016 wr_addr  output  ADDR_W  address of the last committed write; held between writes.
REQ-017 frame_err_cnt  output  8  saturating count of aborted frames.

Function
REQ-018 nCS, SCLK and COPI SHALL each pass through a 3-flop synchroniser; all edge detection SHALL use stages 1 and 2 only.
REQ-019 Operation SHALL be guaranteed for SCLK high and low phases each of at least 5 clk periods.
REQ-020 Frame bit 0 (first shifted) SHALL be R/W (1 = write, 0 = read), followed by ADDR_W address bits, then DATA_W data bits.
REQ-021 Synchronised nCS falling edge SHALL clear the shift register and the bit counter, forcing state CMD.
REQ-022 The FSM SHALL have states IDLE, CMD, DATA, COMMIT: IDLE->CMD on nCS fall; CMD->DATA after bit 1+ADDR_W is sampled; DATA->COMMIT on nCS rise; CMD->IDLE on nCS rise; COMMIT->IDLE after one cycle.
REQ-023 On each synchronised SCLK rising edge with nCS low, COPI SHALL be shifted in; the bit counter saturates at FRAME_W+1.
REQ-024 On a read frame entering DATA, the selected register SHALL be loaded into the output shift register; an address >= NUM_REGS SHALL load zero.
REQ-025 CIPO SHALL change only on synchronised SCLK falling edges, presenting data MSB first; CIPO SHALL be 0 during CMD and in IDLE.
REQ-026 In COMMIT, a write frame with exactly FRAME_W bits and address < NUM_REGS SHALL update that register, pulse wr_strobe, and load wr_addr, all on the same edge.
REQ-027 A write frame with address >= NUM_REGS SHALL be ignored without error; a read frame SHALL never modify registers.
REQ-028 A frame whose bit count on nCS rise is neither 0 nor FRAME_W SHALL be discarded and SHALL increment frame_err_cnt, which saturates at 255.
REQ-029 A frame with 0 bits SHALL be ignored without error.
REQ-030 A new nCS fall during COMMIT SHALL start the new frame normally, with no commit lost.
REQ-031 regs_out SHALL update no later than 4 clk cycles after the first clk edge that samples nCS high.

Reset
REQ-032 While rst is high: regs_out = RESET_VAL; wr_strobe = 0; wr_addr = 0; frame_err_cnt = 0; CIPO = 0; CIPO_oe = 0; FSM = IDLE; synchroniser nCS stages = 1, other stages = 0.
REQ-033 Reset asserted mid-frame SHALL discard the frame; after release, the block SHALL ignore the remainder of that frame until nCS is seen high.

Verification
REQ-034 Write 0x8455 (reg 4 = 0x55) -> regs_out[39:32] = 0x55, one wr_strobe, wr_addr = 4, all other registers unchanged.
REQ-035 Write reg 2 = 0xA3, then read 0x0200 -> CIPO bits 8..15 = 1010_0011; CIPO = 0 for bits 0..7; registers unchanged.
REQ-036 Read 0x7F00 and write 0xFF12 (address >= NUM_REGS) -> read returns 0x00; no wr_strobe; frame_err_cnt unchanged.
REQ-037 Abort a write after 10 bits -> no register change; frame_err_cnt increments by 1; 300 aborted frames -> frame_err_cnt = 255.
REQ-038 Assert rst after 12 bits of a write to reg 0 -> regs_out = RESET_VAL; no wr_strobe; the next full write succeeds.
REQ-039 Back-to-back writes, nCS high for 2 clk -> both registers updated, two wr_strobe pulses; repeat with DATA_W=16, NUM_REGS=4.
